// File: rtl/pcie_us_cq_bar_demux_pkg.sv
// Shared definitions for the CQ BAR demultiplexer: state encoding, descriptor
// field offsets and the BAR routing helper.
package pcie_us_cq_bar_demux_pkg;

    typedef enum logic [1:0] {
        ST_HDR0,
        ST_HDR1,
        ST_FWD,
        ST_DROP
    } cq_state_t;

    localparam int BEAT_WIDTH      = 64;
    localparam int BAR_ID_MSB      = 114;
    localparam int BAR_ID_LSB      = 112;
    localparam int DWORD_COUNT_MSB = 74;
    localparam int DWORD_COUNT_LSB = 64;
    localparam int BAR_ID_LIMIT    = 6;

    // BAR IDs at or above BAR_ID_LIMIT never reach this helper's result.
    function automatic logic bar_is_m0(input logic [5:0] mask, input logic [2:0] bar_id);
        bar_is_m0 = 1'b0;
        for (int i = 0; i < BAR_ID_LIMIT; i++) begin
            if (int'(bar_id) == i) begin
                bar_is_m0 = mask[i];
            end
        end
    endfunction

endpackage

// File: rtl/pcie_us_cq_out_reg.sv
// Single registered AXI-stream beat feeding one CQ output port.
module pcie_us_cq_out_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 2,
    parameter int USER_WIDTH = 85
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d_tdata,
    input  logic [KEEP_WIDTH-1:0] d_tkeep,
    input  logic                  d_tlast,
    input  logic [USER_WIDTH-1:0] d_tuser,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    assign ready = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= d_tdata;
            m_axis_tkeep  <= d_tkeep;
            m_axis_tlast  <= d_tlast;
            m_axis_tuser  <= d_tuser;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pcie_us_cq_bar_demux.sv
// Routes CQ TLPs from the PCIe hard IP to one of two ports by BAR ID, dropping
// TLPs aimed at BAR IDs 6-7 and flagging TLPs too short to carry a descriptor.
module pcie_us_cq_bar_demux
    import pcie_us_cq_bar_demux_pkg::*;
#(
    parameter int         AXIS_PCIE_DATA_WIDTH    = 64,
    parameter int         AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
    parameter int         AXIS_PCIE_CQ_USER_WIDTH = 85,
    parameter logic [5:0] M0_BAR_MASK             = 6'b000001
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
    input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
    input  logic                               s_axis_cq_tvalid,
    output logic                               s_axis_cq_tready,
    input  logic                               s_axis_cq_tlast,
    input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,
    output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m0_axis_cq_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m0_axis_cq_tkeep,
    output logic                               m0_axis_cq_tvalid,
    input  logic                               m0_axis_cq_tready,
    output logic                               m0_axis_cq_tlast,
    output logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] m0_axis_cq_tuser,
    output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m1_axis_cq_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m1_axis_cq_tkeep,
    output logic                               m1_axis_cq_tvalid,
    input  logic                               m1_axis_cq_tready,
    output logic                               m1_axis_cq_tlast,
    output logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] m1_axis_cq_tuser,
    output logic                               status_drop,
    output logic                               status_error
);

    if (AXIS_PCIE_DATA_WIDTH != BEAT_WIDTH) begin : g_width_check
        $error("pcie_us_cq_bar_demux supports only a 64-bit CQ interface");
    end

    cq_state_t state_q, state_d;

    logic                               hold_valid_q;
    logic [AXIS_PCIE_DATA_WIDTH-1:0]    hold_tdata_q;
    logic [AXIS_PCIE_KEEP_WIDTH-1:0]    hold_tkeep_q;
    logic                               hold_tlast_q;
    logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] hold_tuser_q;
    logic                               hold_load, hold_clear, push;
    logic                               sel_q, sel_d;
    logic                               drop_d, err_d;
    logic [2:0]                         bar_id;
    logic                               route_drop, route_port, sel_now, sel_ready;
    logic                               m0_ready, m1_ready;
    logic                               s_ready, in_fire;

    assign bar_id     = s_axis_cq_tdata[BAR_ID_MSB-BEAT_WIDTH:BAR_ID_LSB-BEAT_WIDTH];
    assign route_drop = (bar_id >= 3'(BAR_ID_LIMIT));
    assign route_port = !bar_is_m0(M0_BAR_MASK, bar_id);
    assign sel_now    = (state_q == ST_HDR1) ? route_port : sel_q;
    assign sel_ready  = sel_now ? m1_ready : m0_ready;
    assign in_fire    = s_axis_cq_tvalid && s_ready;
    assign s_axis_cq_tready = s_ready;

    // The hold register is always empty in HDR0, so beat 0 can always be taken there.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_HDR0: s_ready = 1'b1;
            ST_HDR1: s_ready = route_drop || sel_ready;
            ST_FWD:  s_ready = !hold_valid_q || sel_ready;
            ST_DROP: s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
        if (!rst_n) begin
            s_ready = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        push       = 1'b0;
        drop_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_HDR0: begin
                if (in_fire) begin
                    if (s_axis_cq_tlast) begin
                        err_d = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = ST_HDR1;
                    end
                end
            end
            ST_HDR1: begin
                if (in_fire) begin
                    if (route_drop) begin
                        hold_clear = 1'b1;
                        drop_d     = s_axis_cq_tlast;
                        state_d    = s_axis_cq_tlast ? ST_HDR0 : ST_DROP;
                    end else begin
                        push      = 1'b1;
                        hold_load = 1'b1;
                        sel_d     = route_port;
                        state_d   = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                // Once the tlast beat leaves the hold register, an arriving beat starts the next TLP.
                if (hold_valid_q) begin
                    if (sel_ready) begin
                        push = 1'b1;
                        if (hold_tlast_q) begin
                            if (in_fire && !s_axis_cq_tlast) begin
                                hold_load = 1'b1;
                                state_d   = ST_HDR1;
                            end else begin
                                hold_clear = 1'b1;
                                err_d      = in_fire;
                                state_d    = ST_HDR0;
                            end
                        end else if (in_fire) begin
                            hold_load = 1'b1;
                        end else begin
                            hold_clear = 1'b1;
                        end
                    end
                end else if (in_fire) begin
                    hold_load = 1'b1;
                end
            end
            ST_DROP: begin
                if (in_fire && s_axis_cq_tlast) begin
                    drop_d  = 1'b1;
                    state_d = ST_HDR0;
                end
            end
            default: state_d = ST_HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_HDR0;
            sel_q        <= 1'b0;
            status_drop  <= 1'b0;
            status_error <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            status_drop  <= drop_d;
            status_error <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_tdata_q <= '0;
            hold_tkeep_q <= '0;
            hold_tlast_q <= 1'b0;
            hold_tuser_q <= '0;
        end else if (hold_load) begin
            hold_valid_q <= 1'b1;
            hold_tdata_q <= s_axis_cq_tdata;
            hold_tkeep_q <= s_axis_cq_tkeep;
            hold_tlast_q <= s_axis_cq_tlast;
            hold_tuser_q <= s_axis_cq_tuser;
        end else if (hold_clear) begin
            hold_valid_q <= 1'b0;
        end
    end

    pcie_us_cq_out_reg #(
        .DATA_WIDTH(AXIS_PCIE_DATA_WIDTH),
        .KEEP_WIDTH(AXIS_PCIE_KEEP_WIDTH),
        .USER_WIDTH(AXIS_PCIE_CQ_USER_WIDTH)
    ) u_out_m0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (push && !sel_now),
        .d_tdata      (hold_tdata_q),
        .d_tkeep      (hold_tkeep_q),
        .d_tlast      (hold_tlast_q),
        .d_tuser      (hold_tuser_q),
        .ready        (m0_ready),
        .m_axis_tdata (m0_axis_cq_tdata),
        .m_axis_tkeep (m0_axis_cq_tkeep),
        .m_axis_tvalid(m0_axis_cq_tvalid),
        .m_axis_tready(m0_axis_cq_tready),
        .m_axis_tlast (m0_axis_cq_tlast),
        .m_axis_tuser (m0_axis_cq_tuser)
    );

    pcie_us_cq_out_reg #(
        .DATA_WIDTH(AXIS_PCIE_DATA_WIDTH),
        .KEEP_WIDTH(AXIS_PCIE_KEEP_WIDTH),
        .USER_WIDTH(AXIS_PCIE_CQ_USER_WIDTH)
    ) u_out_m1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (push && sel_now),
        .d_tdata      (hold_tdata_q),
        .d_tkeep      (hold_tkeep_q),
        .d_tlast      (hold_tlast_q),
        .d_tuser      (hold_tuser_q),
        .ready        (m1_ready),
        .m_axis_tdata (m1_axis_cq_tdata),
        .m_axis_tkeep (m1_axis_cq_tkeep),
        .m_axis_tvalid(m1_axis_cq_tvalid),
        .m_axis_tready(m1_axis_cq_tready),
        .m_axis_tlast (m1_axis_cq_tlast),
        .m_axis_tuser (m1_axis_cq_tuser)
    );

endmodule

// File: doc/pcie_us_cq_bar_demux.md
PCIE_US_CQ_BAR_DEMUX -- requirements
Module: pcie_us_cq_bar_demux

Interface
REQ-001 Parameter AXIS_PCIE_DATA_WIDTH, default 64: CQ data width; only 64 is supported, and any other value SHALL fail elaboration.
REQ-002 Parameter AXIS_PCIE_KEEP_WIDTH, default AXIS_PCIE_DATA_WIDTH/32: dword keep width.
REQ-003 Parameter AXIS_PCIE_CQ_USER_WIDTH, default 85: CQ tuser width.
REQ-004 Parameter M0_BAR_MASK, default 6'b000001: bit n set routes BAR ID n to port 0.
REQ-005 Ports SHALL be exactly:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  synchronous reset, active-low
  s_axis_cq_tdata/tkeep/tvalid/tready/tlast/tuser  in (tready out)  64/2/1/1/1/85  CQ stream from the PCIe hard IP
  m0_axis_cq_*  out (tready in)  same widths  CQ stream to pcie_us_axi_master
  m1_axis_cq_*  out (tready in)  same widths  CQ stream for all other BARs
  status_drop  out  1  one-cycle pulse per dropped TLP
  status_error  out  1  one-cycle pulse per malformed TLP
REQ-006 Clocking SHALL use one clock and a synchronous, active-low reset.

Function
REQ-007 Beat 0 (dwords 0-1, address) SHALL be captured into a hold register; routing SHALL be decided on beat 1 (dwords 2-3).
REQ-008 BAR ID SHALL be beat-1 tdata[50:48] (descriptor bits 114:112).
REQ-009 Routing SHALL be: BAR ID 0-5 with M0_BAR_MASK[id]=1 -> port 0; BAR ID 0-5 with mask bit 0 -> port 1; BAR ID 6-7 -> drop.
REQ-010 States SHALL be HDR0 (await beat 0), HDR1 (await beat 1), FWD (stream to selected port), DROP (discard until tlast).
REQ-011 Transitions:
  HDR0 --beat0 accepted, tlast=0--> HDR1
  HDR0 --beat0 accepted, tlast=1--> HDR0, with a status_error pulse
  HDR1 --beat1, route valid--> FWD, or HDR0 if beat1 has tlast
  HDR1 --beat1, drop--> DROP, or HDR0 with a status_drop pulse if beat1 has tlast
  FWD --tlast beat emitted--> HDR0
  DROP --tlast accepted--> HDR0, with a status_drop pulse
REQ-012 Each output port SHALL have one registered beat (tdata/tkeep/tlast/tuser/tvalid); outputs are never combinational from inputs.
REQ-013 Beat 0 SHALL be emitted on the selected port first, with its own tuser, followed by beat 1 and the remaining beats, in order and unmodified.
REQ-014 s_axis_cq_tready:
  1 in HDR0 and DROP
  in HDR1/FWD, SHALL equal (hold register free) or (selected output register empty or its tready high)
REQ-015 Sustained throughput SHALL be one beat per clock when the selected tready is held high.
REQ-016 Latency SHALL be 1 cycle from beat-1 acceptance to beat-0 tvalid on the selected port.
REQ-017 Sequencing: the next TLP's beat 0 SHALL be accepted in the same cycle that the previous TLP's tlast is emitted. The unselected port's tvalid SHALL remain 0.
REQ-018 A stalled output SHALL hold all of its fields stable until the tready handshake completes.
REQ-019 In DROP, every beat SHALL be consumed; no tvalid SHALL be asserted on either port.
REQ-020 A simultaneous input and output handshake SHALL not lose or duplicate a beat.

Reset
REQ-021 While rst_n=0 at a clk edge:
  state -> HDR0
  all tvalid, s_axis_cq_tready, status_drop and status_error -> 0
  data registers -> 0
REQ-022 A reset mid-packet SHALL abandon the packet; the first beat after reset is treated as beat 0.

Structure
REQ-023 A shared package SHALL hold:
  state encoding
  descriptor field offsets (BAR ID 114:112, dword count 74:64)
  BAR ID limit constant 6
REQ-024 The per-port output register SHALL be one sub-module, pcie_us_cq_out_reg, instantiated twice.

Verification
REQ-025 TLP with BAR ID 0, 4 beats, both treadys high -> all 4 beats on m0 unchanged, beat 0 one cycle after beat 1 is accepted, m1 tvalid stays 0.
REQ-026 Back-to-back TLPs (BAR 0, BAR 2), 3 beats each, mask 6'b000001 -> first TLP on m0, second on m1, no idle cycle on input.
REQ-027 TLP with BAR ID 6, 5 beats -> no output tvalid, input tready=1 throughout, single status_drop pulse on the tlast cycle.
REQ-028 Single-beat TLP (tlast on beat 0) -> status_error pulse; the next valid TLP is routed correctly.
REQ-029 m0 tready toggled 1-0-1 every cycle during an 8-beat BAR 0 TLP -> data stable while stalled, all 8 beats delivered in order.
REQ-030 rst_n driven low for 1 cycle after beat 2 of a 6-beat TLP -> all tvalid 0 next cycle, and a fresh TLP is forwarded intact.
